ps2_keypad: RTL and testbench

Upstream input stage for the player controller: receives PS/2 keyboard frames, decodes scan-code set 2 make/break sequences and maintains a 5-bit held-key vector. The vector uses the same bit encoding as the debounced push-button bus, so it can be ORed with it and driven into the Mario controller's `keydown` input. Runs on the 100 MHz system clock.

---
 rtl/dk_input_pkg.sv | 76 +++++++
 rtl/ps2_rx.sv | 112 +++++++++++
 rtl/ps2_keypad.sv | 79 +++++++
 tb/tb_ps2_keypad.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/dk_input_pkg.sv
// Shared scan-code constants, key bit indices and decoder types.
// Imported by ps2_rx, ps2_keypad and the player input path.
package dk_input_pkg;

  localparam logic [7:0] SC_W      = 8'h1D;
  localparam logic [7:0] SC_S      = 8'h1B;
  localparam logic [7:0] SC_A      = 8'h1C;
  localparam logic [7:0] SC_D      = 8'h23;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_UP     = 8'h75;
  localparam logic [7:0] SC_DOWN   = 8'h72;
  localparam logic [7:0] SC_LEFT   = 8'h6B;
  localparam logic [7:0] SC_RIGHT  = 8'h74;
  localparam logic [7:0] SC_ACK    = 8'hFA;
  localparam logic [7:0] SC_BAT    = 8'hAA;
  localparam logic [7:0] SC_ECHO   = 8'hEE;
  localparam logic [7:0] SC_RESEND = 8'hFE;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_JUMP  = 4;
  localparam int NKEYS     = 5;

  typedef logic [NKEYS-1:0] keys_t;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } dec_state_t;

  typedef struct packed {
    logic [7:0] data;
    logic       valid;
    logic       err;
  } rx_byte_t;

  function automatic keys_t base_mask(input logic [7:0] b);
    keys_t m;
    m = '0;
    unique case (b)
      SC_W:     m[KEY_UP]    = 1'b1;
      SC_S:     m[KEY_DOWN]  = 1'b1;
      SC_A:     m[KEY_LEFT]  = 1'b1;
      SC_D:     m[KEY_RIGHT] = 1'b1;
      SC_SPACE: m[KEY_JUMP]  = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  function automatic keys_t ext_mask(input logic [7:0] b);
    keys_t m;
    m = '0;
    unique case (b)
      SC_UP:    m[KEY_UP]    = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

  // Keyboard status replies, never part of a key sequence.
  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_ACK) || (b == SC_BAT) ||
           (b == SC_ECHO) || (b == SC_RESEND);
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: sync, glitch filter, bit counter, timeout, frame check.
// Ports: clk, rst, ps2c, ps2d in; rx (data/valid/err, combinational) out.
// PS2_PARITY_CHECK_EN: also require odd parity.
module ps2_rx
  import dk_input_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     ps2c,
  input  logic     ps2d,
  output rx_byte_t rx
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]         c_sync;
  logic [1:0]         d_sync;
  logic [1:0]         raw;
  logic [1:0]         filt;
  logic [1:0][FW-1:0] fcnt;
  logic               c_prev;
  logic               strobe;
  logic [3:0]         bcnt;
  logic [9:0]         sr;
  logic [TW-1:0]      idle;
  logic               last;
  logic               frame_ok;
  logic               good;

  // Bus idles high: reset syncs/filters to 1 so no false strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_sync <= 2'b11;
      d_sync <= 2'b11;
    end else begin
      c_sync <= {c_sync[0], ps2c};
      d_sync <= {d_sync[0], ps2d};
    end
  end

  assign raw = {d_sync[1], c_sync[1]};

  // A level is taken once FILTER_LEN samples in a row disagree.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt <= 2'b11;
      fcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (raw[i] == filt[i]) begin
          fcnt[i] <= '0;
        end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
          filt[i] <= raw[i];
          fcnt[i] <= '0;
        end else begin
          fcnt[i] <= fcnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_prev <= 1'b1;
      strobe <= 1'b0;
    end else begin
      c_prev <= filt[0];
      strobe <= c_prev & ~filt[0];
    end
  end

  assign last = strobe && (bcnt == 4'd10);

  // sr[0]=start, sr[8:1]=data, sr[9]=parity once 10 bits are in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt <= '0;
      sr   <= '0;
      idle <= '0;
    end else if (strobe) begin
      idle <= '0;
      sr   <= {filt[1], sr[9:1]};
      bcnt <= last ? 4'd0 : bcnt + 4'd1;
    end else if (bcnt != 4'd0) begin
      if (idle == TW'(TIMEOUT_CYCLES - 1)) begin
        bcnt <= '0;
        idle <= '0;
      end else begin
        idle <= idle + 1'b1;
      end
    end else begin
      idle <= '0;
    end
  end

  assign frame_ok = ~sr[0] & filt[1];

`ifdef PS2_PARITY_CHECK_EN
  assign good = frame_ok & (^sr[9:1]);
`else
  assign good = frame_ok;
`endif

  assign rx.data  = sr[8:1];
  assign rx.valid = last & good;
  assign rx.err   = last & ~good;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 keypad: set-2 make/break decoder driving a 5-bit held-key vector.
// Ports: clk, rst, ps2c, ps2d in; keydown, code, code_valid, frame_err out.
// PS2_PARITY_CHECK_EN (optional): drop frames with bad odd parity.
module ps2_keypad
  import dk_input_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic [4:0] keydown,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err
);

  rx_byte_t   rx;
  dec_state_t state;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk (clk),
    .rst (rst),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .rx  (rx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      keydown    <= '0;
      code       <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= rx.valid;
      frame_err  <= rx.err;
      if (rx.valid) begin
        code <= rx.data;
        if (!is_status(rx.data)) begin
          unique case (1'b1)
            state == IDLE: begin
              if (rx.data == SC_EXT)
                state <= EXT;
              else if (rx.data == SC_BREAK)
                state <= BRK;
              else
                keydown <= keydown | base_mask(rx.data);
            end
            state == EXT: begin
              if (rx.data == SC_BREAK) begin
                state <= EXT_BRK;
              end else begin
                keydown <= keydown | ext_mask(rx.data);
                state   <= IDLE;
              end
            end
            state == BRK: begin
              keydown <= keydown & ~base_mask(rx.data);
              state   <= IDLE;
            end
            state == EXT_BRK: begin
              keydown <= keydown & ~ext_mask(rx.data);
              state   <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keypad.sv
// Directed bench for ps2_keypad with an expected-frame scoreboard.
module tb_ps2_keypad;

  localparam int HALF = 20;
  localparam int TMO  = 1500;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2c;
  logic       ps2d;
  logic [4:0] keydown;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;

  typedef struct {
    bit         err;
    logic [7:0] code;
    logic [4:0] keys;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  ps2_keypad #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2c      (ps2c),
    .ps2d      (ps2d),
    .keydown   (keydown),
    .code      (code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every output pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && (code_valid || frame_err)) begin
      if (sb.size() == 0) begin
        check("spurious_pulse", 32'({code_valid, frame_err}), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'({code_valid, frame_err}),
              e.err ? 32'd1 : 32'd2);
        check("code", 32'(code), 32'(e.code));
        check("keydown", 32'(keydown), 32'(e.keys));
      end
    end
  end

  task automatic ps2_bit(input bit b);
    @(negedge clk);
    ps2d = b;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2c = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input bit bad_stop,
                      input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2d = 1'b1;
    repeat (4 * HALF) @(negedge clk);
  endtask

  task automatic frame(input logic [7:0] b, input bit bad_stop,
                       input bit bad_par, input bit err,
                       input logic [7:0] c, input logic [4:0] k);
    exp_t e;
    e.err  = err;
    e.code = c;
    e.keys = k;
    sb.push_back(e);
    send(b, bad_stop, bad_par, 11);
  endtask

  initial begin
    rst  = 1'b1;
    ps2c = 1'b1;
    ps2d = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_keydown", 32'(keydown), 32'd0);
    check("rst_code", 32'(code), 32'd0);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_err", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    send(8'h1D, 1'b0, 1'b0, 5);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_keydown", 32'(keydown), 32'd0);
    check("midrst_code", 32'(code), 32'd0);
    repeat (20) @(negedge clk);

    frame(8'h1D, 0, 0, 0, 8'h1D, 5'b00001);
    frame(8'hF0, 0, 0, 0, 8'hF0, 5'b00001);
    frame(8'h1D, 0, 0, 0, 8'h1D, 5'b00000);
    check("wbrk_code", 32'(code), 32'h1D);

    frame(8'hE0, 0, 0, 0, 8'hE0, 5'b00000);
    frame(8'h6B, 0, 0, 0, 8'h6B, 5'b00100);
    frame(8'h29, 0, 0, 0, 8'h29, 5'b10100);
    frame(8'hE0, 0, 0, 0, 8'hE0, 5'b10100);
    frame(8'hF0, 0, 0, 0, 8'hF0, 5'b10100);
    frame(8'h6B, 0, 0, 0, 8'h6B, 5'b10000);

    frame(8'h6B, 0, 0, 0, 8'h6B, 5'b10000);
    frame(8'h29, 0, 0, 0, 8'h29, 5'b10000);

    frame(8'hE0, 0, 0, 0, 8'hE0, 5'b10000);
    frame(8'hFA, 0, 0, 0, 8'hFA, 5'b10000);
    frame(8'h75, 0, 0, 0, 8'h75, 5'b10001);
    frame(8'hF0, 0, 0, 0, 8'hF0, 5'b10001);
    frame(8'h1D, 0, 0, 0, 8'h1D, 5'b10000);

    frame(8'h55, 1, 0, 1, 8'h1D, 5'b10000);
`ifdef PS2_PARITY_CHECK_EN
    frame(8'h29, 0, 1, 1, 8'h1D, 5'b10000);
`else
    frame(8'h29, 0, 1, 0, 8'h29, 5'b10000);
`endif

    send(8'h23, 1'b0, 1'b0, 4);
    repeat (TMO + 200) @(negedge clk);
    frame(8'h23, 0, 0, 0, 8'h23, 5'b11000);

    repeat (50) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("final_keydown", 32'(keydown), 32'h18);
    check("final_code", 32'(code), 32'h23);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
